// File: rtl/pulse_burst_gen.sv
// Pulse-burst transmitter: replays a RAM-held waveform as num_pulses AXI-stream packets.
// Optional build macro PULSE_BURST_GEN_RAMP_EN adds a {pulse, sample} ramp self-test source.
module pulse_burst_gen #(
  parameter int         MAX_PULSE_SIZE = 8192,
  parameter logic [7:0] SR_BASE        = 8'd128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [31:0] o_tdata,
  output logic [15:0] o_tuser,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        busy,
  output logic        done,
  output logic [31:0] pulse_count
);

  localparam int AW = $clog2(MAX_PULSE_SIZE);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, GAP} state_t;

  logic [31:0]   pulse_size_q, num_pulses_q, gap_cycles_q;
  logic [AW-1:0] wptr_q;
  logic [31:0]   mem [MAX_PULSE_SIZE];

  state_t        state_q;
  logic          tvalid_q, tlast_q, busy_q, done_q, abort_q;
  logic [31:0]   tdata_q, pulse_count_q, pidx_q, npulses_q, gap_lat_q, gap_cnt_q;
  logic [15:0]   tuser_q;
  logic [AW-1:0] sidx_q, last_idx_q;
`ifdef PULSE_BURST_GEN_RAMP_EN
  logic          ramp_q;
`endif

  logic          wr_size, wr_num, wr_gap, wr_wave, wr_ctrl, idle;
  logic          start_req, abort_req, hs, last_sample, last_pulse, end_burst;
  logic [AW:0]   size_eff_d;
  logic [AW-1:0] last_idx_d, rd_addr;
  logic [31:0]   fetch_data;

  assign wr_size = set_stb && (set_addr == SR_BASE);
  assign wr_num  = set_stb && (set_addr == SR_BASE + 8'd1);
  assign wr_gap  = set_stb && (set_addr == SR_BASE + 8'd2);
  assign wr_wave = set_stb && (set_addr == SR_BASE + 8'd3);
  assign wr_ctrl = set_stb && (set_addr == SR_BASE + 8'd4);
  assign idle    = (state_q == IDLE);

  // Abort dominates start when both bits arrive in the same control write.
  assign abort_req   = wr_ctrl && set_data[1];
  assign start_req   = wr_ctrl && set_data[0] && !set_data[1] && idle && (num_pulses_q != '0);
  assign hs          = tvalid_q && o_tready;
  assign last_sample = (sidx_q == last_idx_q);
  assign last_pulse  = (pidx_q == npulses_q - 32'd1);
  assign end_burst   = ((state_q == PRIME || state_q == GAP) && abort_req) ||
                       ((state_q == RUN) && hs &&
                        (abort_q || (last_sample && (last_pulse || abort_req))));

  // NOTE: every path assigns size_eff_d, so no latch is inferred.
  always_comb begin
    size_eff_d = (AW+1)'(MAX_PULSE_SIZE);
    if (pulse_size_q == 32'd0)
      size_eff_d = (AW+1)'(1);
    else if (pulse_size_q <= 32'(MAX_PULSE_SIZE))
      size_eff_d = pulse_size_q[AW:0];
  end
  assign last_idx_d = AW'(size_eff_d - (AW+1)'(1));

  // Read-ahead address: sample 0 while priming, otherwise the sample after the one on the bus.
  assign rd_addr = (state_q == RUN) ? sidx_q + AW'(1) : '0;
`ifdef PULSE_BURST_GEN_RAMP_EN
  assign fetch_data = ramp_q ? {pidx_q[15:0], 16'(rd_addr)} : mem[rd_addr];
`else
  assign fetch_data = mem[rd_addr];
`endif

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_size_q <= 32'(MAX_PULSE_SIZE);
      num_pulses_q <= 32'd1;
      gap_cycles_q <= '0;
      wptr_q       <= '0;
    end else begin
      if (wr_size) pulse_size_q <= set_data;
      if (wr_num)  num_pulses_q <= set_data;
      if (wr_gap)  gap_cycles_q <= set_data;
      if (wr_wave && idle)
        wptr_q <= wptr_q + AW'(1);
      else if (wr_ctrl && set_data[2] && idle)
        wptr_q <= '0;
    end
  end

  // NOTE: the waveform RAM has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_wave && idle) mem[wptr_q] <= set_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
      tuser_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      pulse_count_q <= '0;
      pidx_q        <= '0;
      sidx_q        <= '0;
      last_idx_q    <= '0;
      npulses_q     <= '0;
      gap_lat_q     <= '0;
      gap_cnt_q     <= '0;
`ifdef PULSE_BURST_GEN_RAMP_EN
      ramp_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if ((state_q == RUN) && hs && last_sample)
        pulse_count_q <= pulse_count_q + 32'd1;
      if (end_burst) begin
        state_q  <= IDLE;
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (start_req) begin
            state_q       <= PRIME;
            busy_q        <= 1'b1;
            abort_q       <= 1'b0;
            pulse_count_q <= '0;
            pidx_q        <= '0;
            sidx_q        <= '0;
            last_idx_q    <= last_idx_d;
            npulses_q     <= num_pulses_q;
            gap_lat_q     <= gap_cycles_q;
`ifdef PULSE_BURST_GEN_RAMP_EN
            ramp_q        <= set_data[3];
`endif
          end
          PRIME: begin
            state_q  <= RUN;
            tvalid_q <= 1'b1;
            tlast_q  <= (last_idx_q == '0);
            tuser_q  <= pidx_q[15:0];
            tdata_q  <= fetch_data;
            sidx_q   <= '0;
          end
          RUN: if (hs) begin
            if (last_sample) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              pidx_q   <= pidx_q + 32'd1;
              if (gap_lat_q == '0) begin
                state_q <= PRIME;
              end else begin
                state_q   <= GAP;
                gap_cnt_q <= gap_lat_q - 32'd1;
              end
            end else begin
              // An abort landing on an accepted beat truncates the pulse at the next beat.
              sidx_q  <= rd_addr;
              tdata_q <= fetch_data;
              tlast_q <= (rd_addr == last_idx_q) || abort_req;
              abort_q <= abort_req;
            end
          end else if (abort_req) begin
            tlast_q <= 1'b1;
            abort_q <= 1'b1;
          end
          GAP: begin
            if (gap_cnt_q == '0) state_q <= PRIME;
            else                 gap_cnt_q <= gap_cnt_q - 32'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_tdata     = tdata_q;
  assign o_tuser     = tuser_q;
  assign o_tlast     = tlast_q;
  assign o_tvalid    = tvalid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Scoreboard bench for pulse_burst_gen: stimulus queues expected beats, a monitor pops them.
// Ramp expectations follow PULSE_BURST_GEN_RAMP_EN when the build defines it.
module tb_pulse_burst_gen;

  localparam int         MAX = 8192;
  localparam logic [7:0] B   = 8'd128;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        o_tready = 1'b0;
  logic [31:0] o_tdata;
  logic [15:0] o_tuser;
  logic        o_tlast, o_tvalid, busy, done;
  logic [31:0] pulse_count;

  pulse_burst_gen #(.MAX_PULSE_SIZE(MAX), .SR_BASE(B)) dut (
    .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .busy(busy), .done(done),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] user;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [31:0] mem_m [MAX];
  int          wptr_m = 0;
  int          total = 0, bad = 0;
  int          cyc = 0, done_cnt = 0, beat_cnt = 0;
  int          start_cyc = 0, tlast_cyc = 0, hs_cyc = 0, gap_exp = 0;
  bit          lat_armed = 0, gap_armed = 0, rand_en = 0;
  bit          pend = 0, prev_valid = 0;
  logic [31:0] h_data;
  logic [15:0] h_user;
  logic        h_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rand_en) begin
    #1 o_tready = ($urandom_range(0, 1) == 1);
  end

  // Monitor: AXI hold rules, spacing, and in-order scoreboard comparison.
  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 0;
      prev_valid = 0;
    end else begin
      if (pend)
        check("stall_hold", 64'({o_tvalid, o_tdata, o_tuser, h_last & ~o_tlast}),
              64'({1'b1, h_data, h_user, 1'b0}));
      if (o_tvalid && !prev_valid) begin
        if (lat_armed) begin
          check("start_latency", 64'(cyc - start_cyc), 64'd2);
          lat_armed = 0;
        end
        if (gap_armed) begin
          check("pulse_spacing", 64'(cyc - tlast_cyc), 64'(gap_exp + 2));
          gap_armed = 0;
        end
      end
      if (o_tvalid && o_tready) begin
        beat_cnt++;
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0h expected no beat", {o_tdata, o_tuser, o_tlast});
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 64'({o_tdata, o_tuser, o_tlast}), 64'(mon_e));
        end
        if (o_tlast) begin
          tlast_cyc = cyc;
          gap_armed = 1;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", 64'(busy), 64'd0);
        check("done_timing", 64'(cyc - hs_cyc), 64'd1);
        gap_armed = 0;
      end
      pend = o_tvalid && !o_tready;
      h_data = o_tdata;
      h_user = o_tuser;
      h_last = o_tlast;
      prev_valid = o_tvalid;
    end
  end

  task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1 set_stb = 1'b0;
  endtask

  task automatic wave_write(input logic [31:0] d);
    sr_write(B + 8'd3, d);
    mem_m[wptr_m] = d;
    wptr_m = (wptr_m + 1) % MAX;
  endtask

  task automatic wave_clear();
    sr_write(B + 8'd4, 32'h4);
    wptr_m = 0;
  endtask

  task automatic set_cfg(input int size, input int num, input int gap);
    sr_write(B, 32'(size));
    sr_write(B + 8'd1, 32'(num));
    sr_write(B + 8'd2, 32'(gap));
    gap_exp = gap;
  endtask

  task automatic start_burst(input logic [31:0] ctrl, input bit acc);
    if (acc) begin
      start_cyc = cyc;
      lat_armed = 1;
    end
    sr_write(B + 8'd4, ctrl);
  endtask

  task automatic push_beat(input logic [31:0] d, input int p, input bit l);
    beat_t b;
    b.data = d;
    b.user = 16'(p);
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic push_burst(input int size, input int np);
    for (int p = 0; p < np; p++)
      for (int s = 0; s < size; s++)
        push_beat(mem_m[s], p, s == size - 1);
  endtask

  task automatic end_burst(input int pc, input int limit);
    int n0 = done_cnt;
    int i = 0;
    while (done_cnt == n0 && i < limit) begin
      @(posedge clk);
      #1 i++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt - n0), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("pulse_count", 64'(pulse_count), 64'(pc));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({o_tdata, o_tuser, o_tvalid, o_tlast, busy, done}), 64'd0);
    check({tag, "_count"}, 64'(pulse_count), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, b0;
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    reset_n = 1'b1;
    o_tready = 1'b1;

    // Basic replay: 0..7, three pulses back to back.
    for (int i = 0; i < 8; i++) wave_write(32'(i));
    set_cfg(8, 3, 0);
    push_burst(8, 3);
    start_burst(32'h1, 1);
    end_burst(3, 200);

    // Inter-pulse gap of 5 cycles.
    set_cfg(4, 2, 5);
    push_burst(4, 2);
    start_burst(32'h1, 1);
    end_burst(2, 200);

    // Random backpressure over 400 beats.
    wave_clear();
    for (int i = 0; i < 100; i++) wave_write(32'hA000_0000 + 32'(i * 3));
    set_cfg(100, 4, 0);
    push_burst(100, 4);
    rand_en = 1;
    start_burst(32'h1, 1);
    end_burst(4, 5000);
    rand_en = 0;
    @(posedge clk);
    #2 o_tready = 1'b1;

    // Abort during pulse 1, beat 5: beat 6 ends the burst with tlast.
    set_cfg(16, 4, 0);
    push_burst(16, 1);
    for (int s = 0; s <= 6; s++) push_beat(mem_m[s], 1, s == 6);
    start_burst(32'h1, 1);
    repeat (23) @(posedge clk);
    #1 sr_write(B + 8'd4, 32'h2);
    end_burst(1, 200);

    // Abort while the first beat is stalled: that beat gains tlast.
    o_tready = 1'b0;
    set_cfg(16, 2, 0);
    push_beat(mem_m[0], 0, 1'b1);
    start_burst(32'h1, 1);
    repeat (2) @(posedge clk);
    #1 sr_write(B + 8'd4, 32'h2);
    o_tready = 1'b1;
    end_burst(0, 200);

    // Normal burst after abort, then abort in IDLE does nothing.
    set_cfg(4, 1, 0);
    push_burst(4, 1);
    start_burst(32'h1, 1);
    end_burst(1, 200);
    n0 = done_cnt;
    sr_write(B + 8'd4, 32'h2);
    repeat (3) @(posedge clk);
    #1 check("idle_abort_done", 64'(done_cnt - n0), 64'd0);
    check("idle_abort_busy", 64'(busy), 64'd0);

    // pulse_size 0 behaves as 1.
    set_cfg(0, 2, 0);
    push_burst(1, 2);
    start_burst(32'h1, 1);
    end_burst(2, 200);

    // Full RAM fill, wrap write to address 0, oversize clamps to 8192.
    wave_clear();
    for (int i = 0; i < MAX; i++) wave_write(32'h5A5A_0000 ^ 32'(i * 7));
    wave_write(32'hCAFE_0001);
    set_cfg(9000, 1, 0);
    push_burst(MAX, 1);
    start_burst(32'h1, 1);
    end_burst(1, 9000);

    // num_pulses 0: start ignored.
    set_cfg(4, 0, 0);
    n0 = done_cnt;
    b0 = beat_cnt;
    start_burst(32'h1, 0);
    repeat (10) @(posedge clk);
    #1 check("np0_busy", 64'(busy), 64'd0);
    check("np0_beats", 64'(beat_cnt - b0), 64'd0);
    check("np0_done", 64'(done_cnt - n0), 64'd0);

    // Start and waveform write while busy are both ignored.
    set_cfg(4, 2, 3);
    push_burst(4, 2);
    start_burst(32'h1, 1);
    sr_write(B + 8'd3, 32'hDEAD_BEEF);
    sr_write(B + 8'd4, 32'h1);
    end_burst(2, 200);
    set_cfg(2, 1, 0);
    push_burst(2, 1);
    start_burst(32'h1, 1);
    end_burst(1, 200);

    // Ramp select bit.
    set_cfg(4, 2, 0);
`ifdef PULSE_BURST_GEN_RAMP_EN
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++)
        push_beat({16'(p), 16'(s)}, p, s == 3);
`else
    push_burst(4, 2);
`endif
    start_burst(32'h9, 1);
    end_burst(2, 200);

    // Reset mid-burst clears everything asynchronously.
    set_cfg(100, 1, 0);
    push_burst(100, 1);
    start_burst(32'h1, 1);
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    exp_q.delete();
    lat_armed = 0;
    gap_armed = 0;
    gap_exp = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    b0 = beat_cnt;
    repeat (5) @(posedge clk);
    #1 check_reset_outputs("reset_after");
    check("reset_no_beats", 64'(beat_cnt - b0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

Pulse-burst transmitter for the pulse-averaging chain: stores one pulse waveform in on-chip RAM loaded over the settings bus, then replays it as a burst of `num_pulses` identical AXI-stream packets of `pulse_size` 32-bit samples. Inter-pulse gaps are programmable. The block sits in the compute-engine clock domain on the transmit side of the datapath. Its output framing (one packet per pulse, `tlast` on the final sample, pulse index in `tuser`) is exactly the framing the pulse averager consumes, so the same registers that set averaging length also size the burst.

## Interface
Parameters:
- `MAX_PULSE_SIZE`, 8192: waveform RAM depth. Must be a power of 2.
- `SR_BASE`, 8'd128: settings-bus base address.
  - `SR_BASE+0`: pulse_size.
  - `SR_BASE+1`: num_pulses.
  - `SR_BASE+2`: gap_cycles.
  - `SR_BASE+3`: waveform write data.
  - `SR_BASE+4`: control.

Ports:
- `clk` in 1: compute-engine clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `set_stb` in 1: settings write strobe.
- `set_addr` in 8: settings address.
- `set_data` in 32: settings data.
- `o_tdata` out 32: sample.
- `o_tuser` out 16: pulse index within burst, 0-based.
- `o_tlast` out 1: last sample of pulse.
- `o_tvalid` out 1: AXI valid.
- `o_tready` in 1: AXI ready.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst end (normal end or abort).
- `pulse_count` out 32: pulses fully sent in the current or last burst.

## Operation
- Registers reset to:
  - pulse_size = MAX_PULSE_SIZE
  - num_pulses = 1
  - gap_cycles = 0
  - write pointer = 0
- Effective size rules:
  - pulse_size 0 is treated as 1.
  - pulse_size > MAX_PULSE_SIZE is clamped to MAX_PULSE_SIZE.
  - These are latched at start; writes during a burst take effect on the next burst.
- Waveform write (`SR_BASE+3`):
  - Writes RAM[wptr], then wptr increments.
  - wptr wraps from MAX_PULSE_SIZE-1 to 0.
  - Ignored while busy.
- Control (`SR_BASE+4`), bits:
  - [0] start: ignored if busy or num_pulses==0.
  - [1] abort.
  - [2] clear wptr: ignored while busy.
  - [3] ramp select; see Configuration.
  - Other bits ignored.
  - start and abort in the same write: abort wins, start dropped.
- FSM states: IDLE, PRIME, RUN, GAP.
  - IDLE -> PRIME on accepted start. busy=1, pulse_count cleared, sample index 0, pulse index 0.
  - PRIME: issue RAM read of address 0, then go to RUN.
  - RUN: present samples. On handshake (tvalid&tready) of a tlast beat, pulse_count increments, then:
    - if last pulse: IDLE, done=1, busy=0;
    - else if gap_cycles==0: PRIME;
    - else: GAP.
  - GAP: count gap_cycles cycles with tvalid=0, then PRIME.
- Abort:
  - If a beat is currently presented, it stays valid with tlast forced to 1 until handshake, then the FSM goes to IDLE and done=1. pulse_count does not increment for a truncated pulse.
  - From PRIME or GAP: immediate IDLE, done=1.
  - In IDLE: no effect.
- AXI rule: once tvalid is asserted, tdata/tuser/tlast are held stable until handshake. tvalid never drops without a handshake.
- `o_tuser` = pulse index [15:0]. It wraps past 65535; pulse_count does not wrap below 2^32.

## Timing
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0, busy=0, done=0, pulse_count=0, FSM=IDLE. RAM contents are not reset.
- Start write in cycle N: busy=1 at N+1 (PRIME); first o_tvalid at N+2.
- With o_tready held high: one beat per cycle, no bubbles within a pulse.
- Pulse-to-pulse spacing with gap_cycles=G: last beat handshake in cycle M -> next first beat valid at M+2+G, due to the PRIME cycle.
- Backpressure: RAM read-ahead plus output register sustains full rate. Any o_tready pattern gives no lost or duplicated samples.
- done asserts the cycle after the final handshake, together with busy falling.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronously); no partial packet completion.

## Configuration
- `PULSE_BURST_GEN_RAMP_EN`:
  - Defined: control bit [3], latched at start, replaces RAM data with {pulse index[15:0], sample index[15:0]} for self-test without loading RAM.
  - Undefined: bit [3] ignored; data always comes from RAM.

## Test plan
- Load RAM with 0..7, pulse_size=8, num_pulses=3, gap=0, tready=1, start -> 24 beats: data 0..7 repeating, tlast on beats 8/16/24, tuser 0/1/2, done once, pulse_count=3.
- gap_cycles=5, pulse_size=4, num_pulses=2 -> exactly 6 idle cycles between the tlast handshake and the next tvalid; first tvalid 2 cycles after start.
- Random tready (50%), pulse_size=100, num_pulses=4 -> 400 beats in RAM order, stable data under stall, no valid drop.
- Abort mid-pulse 2 of 4 (pulse_size=16) -> the held beat completes with tlast=1, done pulses, pulse_count=1, busy=0; a following start works normally.
- pulse_size=0 -> 1-beat pulses; pulse_size=9000 -> 8192-beat pulses; num_pulses=0 start -> no activity, busy stays 0; start while busy ignored.
- Ramp build, bit3=1, pulse_size=4, num_pulses=2 -> data 0x00000000..0x00000003, then 0x00010000..0x00010003.
